// File: rtl/handshake_dispatch_if.sv
// Upstream and three-channel downstream handshake bundle for handshake_dispatch.
interface handshake_dispatch_if;
  logic       handshake_valid;
  logic       handshake_ready;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       handshake_arr_0_valid;
  logic       handshake_arr_1_valid;
  logic       handshake_arr_2_valid;
  logic       handshake_arr_0_ready;
  logic       handshake_arr_1_ready;
  logic       handshake_arr_2_ready;
  logic [7:0] handshake_arr_0_data;
  logic [7:0] handshake_arr_1_data;
  logic [7:0] handshake_arr_2_data;
  logic       out;
  logic [7:0] xfer_count;

  modport master (
    output handshake_valid, in1, in2,
    output handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    input  handshake_ready,
    input  handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    input  handshake_arr_0_data, handshake_arr_1_data, handshake_arr_2_data,
    input  out, xfer_count
  );

  modport slave (
    input  handshake_valid, in1, in2,
    input  handshake_arr_0_ready, handshake_arr_1_ready, handshake_arr_2_ready,
    output handshake_ready,
    output handshake_arr_0_valid, handshake_arr_1_valid, handshake_arr_2_valid,
    output handshake_arr_0_data, handshake_arr_1_data, handshake_arr_2_data,
    output out, xfer_count
  );
endinterface

// File: rtl/handshake_dispatch.sv
// 2-entry FIFO feeding three downstream channels in strict round-robin order.
// All outputs are registered; each is computed from the next-state values.
module handshake_dispatch (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  handshake_dispatch_if.slave  bus
);
  typedef enum logic [1:0] {CH0 = 2'd0, CH1 = 2'd1, CH2 = 2'd2} chan_t;

  chan_t      ptr, ptr_n;
  logic       rst_done;
  logic [1:0] count, count_n;
  logic       rd, wr, rd_n;
  logic [7:0] mem [2];
  logic [7:0] word, head_n, xfer;
  logic       ready_q, out_q;
  logic [2:0] valid_q, valid_n, ready_in;
  logic [7:0] data_q [3];
  logic [7:0] data_n [3];
  logic       push, pop;

  always_comb begin
    word     = {bus.in2, bus.in1};
    ready_in = {bus.handshake_arr_2_ready, bus.handshake_arr_1_ready, bus.handshake_arr_0_ready};
    push     = bus.handshake_valid & ready_q & rst_done;
    pop      = (|(valid_q & ready_in)) & rst_done;
    count_n  = count + 2'(push) - 2'(pop);
    rd_n     = rd ^ pop;
    ptr_n    = ptr;
    if (pop) begin
      case (ptr)
        CH0:     ptr_n = CH1;
        CH1:     ptr_n = CH2;
        default: ptr_n = CH0;
      endcase
    end
    // A word pushed into the slot that becomes head is not yet in mem.
    head_n  = (push && (wr == rd_n)) ? word : mem[rd_n];
    valid_n = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      data_n[i] = '0;
      if ((count_n != 2'd0) && (ptr_n == i[1:0])) begin
        valid_n[i] = 1'b1;
        data_n[i]  = head_n;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      rst_done <= 1'b0;
      count    <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      ptr      <= CH0;
      xfer     <= '0;
      ready_q  <= 1'b0;
      out_q    <= 1'b0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) data_q[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      count    <= count_n;
      rd       <= rd_n;
      wr       <= wr ^ push;
      if (push) mem[wr] <= word;
      ptr      <= ptr_n;
      xfer     <= xfer + 8'(pop);
      ready_q  <= (count_n < 2'd2);
      out_q    <= (count_n == 2'd0);
      valid_q  <= valid_n;
      for (int unsigned i = 0; i < 3; i++) data_q[i] <= data_n[i];
    end
  end

  assign bus.handshake_ready       = ready_q;
  assign bus.out                   = out_q;
  assign bus.xfer_count            = xfer;
  assign bus.handshake_arr_0_valid = valid_q[0];
  assign bus.handshake_arr_1_valid = valid_q[1];
  assign bus.handshake_arr_2_valid = valid_q[2];
  assign bus.handshake_arr_0_data  = data_q[0];
  assign bus.handshake_arr_1_data  = data_q[1];
  assign bus.handshake_arr_2_data  = data_q[2];
endmodule

// File: tb/tb_handshake_dispatch.sv
// Bench for handshake_dispatch: directed vector table, corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_handshake_dispatch;
  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;

  handshake_dispatch_if bus ();
  handshake_dispatch dut (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus));

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  int         m_ptr;
  int         m_cnt;
  bit         m_done;

  logic [2:0] dv;
  logic [7:0] dd [3];
  assign dv    = {bus.handshake_arr_2_valid, bus.handshake_arr_1_valid, bus.handshake_arr_0_valid};
  assign dd[0] = bus.handshake_arr_0_data;
  assign dd[1] = bus.handshake_arr_1_data;
  assign dd[2] = bus.handshake_arr_2_data;

  typedef struct {
    logic       v;
    logic [7:0] w;
    logic [2:0] rdy;
    logic       e_ready;
    logic       e_out;
    logic [2:0] e_valid;
    logic [7:0] e_data;
    logic [7:0] e_cnt;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] w, input logic [2:0] rdy);
    bus.handshake_valid       = v;
    bus.in1                   = w[3:0];
    bus.in2                   = w[7:4];
    bus.handshake_arr_0_ready = rdy[0];
    bus.handshake_arr_1_ready = rdy[1];
    bus.handshake_arr_2_ready = rdy[2];
  endtask

  function automatic bit m_ready();
    return m_done && (q.size() < 2);
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr  = 0;
    m_cnt  = 0;
    m_done = 0;
  endtask

  task automatic check_model();
    bit         ev;
    logic [7:0] ed;
    check("ready", 32'(bus.handshake_ready), 32'(m_ready()));
    check("idle", 32'(bus.out), 32'(m_done && (q.size() == 0)));
    check("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
    for (int i = 0; i < 3; i++) begin
      ev = m_done && (q.size() > 0) && (m_ptr == i);
      ed = 8'h00;
      if (ev) ed = q[0];
      check($sformatf("valid%0d", i), 32'(dv[i]), 32'(ev));
      check($sformatf("data%0d", i), 32'(dd[i]), 32'(ed));
    end
  endtask

  // One clock: the model applies the spec rules to the inputs seen at the edge.
  task automatic tick();
    bit         fin, fout;
    logic [2:0] rv;
    logic [7:0] w;
    @(posedge CLK);
    if (ASYNCRESETN) begin
      w    = {bus.in2, bus.in1};
      rv   = {bus.handshake_arr_2_ready, bus.handshake_arr_1_ready, bus.handshake_arr_0_ready};
      fin  = bus.handshake_valid && m_ready();
      fout = m_done && (q.size() > 0) && rv[m_ptr];
      if (fout) begin
        void'(q.pop_front());
        m_ptr = (m_ptr + 1) % 3;
        m_cnt = (m_cnt + 1) % 256;
      end
      if (fin) q.push_back(w);
      m_done = 1;
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (3) tick();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.handshake_ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h11, 3'b111, 1'b1, 1'b0, 3'b001, 8'h11, 8'd0};
    vecs[1] = '{1'b1, 8'h22, 3'b111, 1'b1, 1'b0, 3'b010, 8'h22, 8'd1};
    vecs[2] = '{1'b1, 8'h33, 3'b111, 1'b1, 1'b0, 3'b100, 8'h33, 8'd2};
    vecs[3] = '{1'b1, 8'h44, 3'b111, 1'b1, 1'b0, 3'b001, 8'h44, 8'd3};
    vecs[4] = '{1'b0, 8'h00, 3'b111, 1'b1, 1'b1, 3'b000, 8'h00, 8'd4};

    // Reset release with upstream valid already high.
    drive(1'b1, 8'h99, 3'b000);
    model_reset();
    do_reset();
    tick();
    check("rel_ready", 32'(bus.handshake_ready), 32'd1);
    check("rel_out", 32'(bus.out), 32'd1);
    check("rel_valid", 32'(dv), 32'd0);
    check("rel_cnt", 32'(bus.xfer_count), 32'd0);
    tick();
    check("rel_accept_v", 32'(dv), 32'b001);
    check("rel_accept_d", 32'(dd[0]), 32'h99);
    drive(1'b0, 8'h00, 3'b111);
    tick();

    // Round-robin vector table.
    drive(1'b0, 8'h00, 3'b000);
    do_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(vecs[k].v, vecs[k].w, vecs[k].rdy);
      tick();
      check($sformatf("rr%0d_ready", k), 32'(bus.handshake_ready), 32'(vecs[k].e_ready));
      check($sformatf("rr%0d_out", k), 32'(bus.out), 32'(vecs[k].e_out));
      check($sformatf("rr%0d_valid", k), 32'(dv), 32'(vecs[k].e_valid));
      for (int i = 0; i < 3; i++)
        check($sformatf("rr%0d_data%0d", k, i), 32'(dd[i]),
              vecs[k].e_valid[i] ? 32'(vecs[k].e_data) : 32'd0);
      check($sformatf("rr%0d_cnt", k), 32'(bus.xfer_count), 32'(vecs[k].e_cnt));
    end

    // Backpressure on channel 0; channel 1 ready must be ignored.
    drive(1'b0, 8'h00, 3'b000);
    do_reset();
    tick();
    drive(1'b1, 8'hA5, 3'b000); tick();
    drive(1'b1, 8'h5A, 3'b000); tick();
    check("bp_full_ready", 32'(bus.handshake_ready), 32'd0);
    drive(1'b1, 8'h3C, 3'b010); tick();
    check("bp_hold_v", 32'(dv), 32'b001);
    check("bp_hold_d", 32'(dd[0]), 32'hA5);
    check("bp_hold_cnt", 32'(bus.xfer_count), 32'd0);
    drive(1'b1, 8'h3C, 3'b001); tick();
    check("bp_pop_v", 32'(dv), 32'b010);
    check("bp_pop_d", 32'(dd[1]), 32'h5A);
    drive(1'b1, 8'h3C, 3'b000); tick();
    check("bp_refill_ready", 32'(bus.handshake_ready), 32'd0);

    // Simultaneous push/pop at occupancy 1.
    drive(1'b0, 8'h00, 3'b010); tick();
    check("pp_pre_d", 32'(dd[2]), 32'h3C);
    drive(1'b1, 8'h77, 3'b100); tick();
    check("pp_v", 32'(dv), 32'b001);
    check("pp_d", 32'(dd[0]), 32'h77);
    check("pp_ready", 32'(bus.handshake_ready), 32'd1);
    drive(1'b0, 8'h00, 3'b001); tick();

    // Counter wrap after 256 transfers.
    drive(1'b0, 8'h00, 3'b000);
    do_reset();
    tick();
    for (int i = 1; i <= 257; i++) begin
      drive(1'b1, 8'(i), 3'b111);
      tick();
      if (i == 256) check("wrap_255", 32'(bus.xfer_count), 32'd255);
      if (i == 257) begin
        check("wrap_0", 32'(bus.xfer_count), 32'd0);
        check("wrap_ptr", 32'(dv), 32'b010);
      end
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom));
      tick();
    end

    // Reset asserted while channel 1 holds a word.
    drive(1'b0, 8'h00, 3'b000);
    do_reset();
    tick();
    drive(1'b1, 8'h11, 3'b000); tick();
    drive(1'b1, 8'h22, 3'b001); tick();
    drive(1'b0, 8'h00, 3'b000); tick();
    check("mid_pre_v", 32'(dv), 32'b010);
    check("mid_pre_d", 32'(dd[1]), 32'h22);
    @(negedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    check("mid_valid", 32'(dv), 32'd0);
    check("mid_cnt", 32'(bus.xfer_count), 32'd0);
    check_model();
    repeat (2) tick();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    drive(1'b0, 8'h00, 3'b111);
    repeat (4) tick();
    check("mid_after_v", 32'(dv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
